// File: rtl/seq_pattern_counter.sv
// seq_pattern_counter
//   Watches a qualified serial bit stream for a programmable PAT_W-bit
//   pattern (MSB = oldest bit) and counts matches. Overlapping or
//   non-overlapping matching is selected at run time by overlap_en.
//
// Parameters
//   PAT_W    pattern length, 2..16
//   PAT_INIT pattern loaded at reset
//   CNT_W    match counter width
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   x, x_valid   serial data bit and its qualifier
//   overlap_en   1 = overlapping matches, 0 = history restarts after a match
//   cfg_load     load cfg_pattern and flush history (bit in this cycle dropped)
//   cfg_pattern  new pattern
//   cnt_clr      clear match counter (a same-cycle match then counts as 1)
//   y            registered one-cycle detect pulse
//   users_count  number of matches
//   cnt_full     counter limit indication
//
// Build option
//   SEQ_CNT_SATURATE_EN defined : counter saturates, cnt_full is a level
//                                 while users_count is at its maximum.
//   undefined (default)         : counter wraps, cnt_full pulses with y on
//                                 the wrap edge.
module seq_pattern_counter #(
  parameter int              PAT_W    = 4,
  parameter logic [PAT_W-1:0] PAT_INIT = 4'b1011,
  parameter int              CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap_en,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] users_count,
  output logic             cnt_full
);

  localparam int              FW       = $clog2(PAT_W);
  localparam logic [FW-1:0]   FILL_MAX = FW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PAT_W-1:0] pattern;
  logic [PAT_W-2:0] shreg;
  logic [FW-1:0]    fill;

  logic [PAT_W-1:0] hist;
  logic             match;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_nxt;
  logic             full_nxt;

  // Candidate window: stored history plus the bit on the wire. Slicing the
  // low PAT_W-1 bits of it is the shift, which also covers PAT_W == 2.
  assign hist  = {shreg, x};
  assign match = x_valid && !cfg_load && (fill == FILL_MAX) && (hist == pattern);

  // Clear is applied before the increment so clear+match yields 1.
  assign cnt_base = cnt_clr ? '0 : users_count;

`ifdef SEQ_CNT_SATURATE_EN
  always_comb begin
    cnt_nxt  = cnt_base;
    if (match && (cnt_base != CNT_MAX)) cnt_nxt = cnt_base + CNT_W'(1);
    full_nxt = (cnt_nxt == CNT_MAX);
  end
`else
  always_comb begin
    cnt_nxt  = cnt_base;
    if (match) cnt_nxt = cnt_base + CNT_W'(1);
    full_nxt = match && (cnt_base == CNT_MAX);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern     <= PAT_INIT;
      shreg       <= '0;
      fill        <= '0;
      y           <= 1'b0;
      users_count <= '0;
      cnt_full    <= 1'b0;
    end else begin
      y           <= match;
      users_count <= cnt_nxt;
      cnt_full    <= full_nxt;
      if (cfg_load) begin
        pattern <= cfg_pattern;
        shreg   <= '0;
        fill    <= '0;
      end else if (x_valid) begin
        if (match && !overlap_en) begin
          // Non-overlap: the completed match consumes the whole history.
          shreg <= '0;
          fill  <= '0;
        end else begin
          shreg <= hist[PAT_W-2:0];
          if (fill != FILL_MAX) fill <= fill + FW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_counter.sv
module tb_seq_pattern_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       overlap_en = 1'b1;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_pattern = 4'b0000;
  logic       cnt_clr = 1'b0;

  logic       y, cnt_full;
  logic [9:0] users_count;
  logic       s_y, s_full;
  logic [2:0] s_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seq_pattern_counter #(.PAT_W(4), .PAT_INIT(4'b1011), .CNT_W(10)) u_dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap_en(overlap_en),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr),
    .y(y), .users_count(users_count), .cnt_full(cnt_full)
  );

  // Narrow-counter instance for the limit behaviour; shares all inputs.
  seq_pattern_counter #(.PAT_W(4), .PAT_INIT(4'b1011), .CNT_W(3)) u_small (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap_en(overlap_en),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr),
    .y(s_y), .users_count(s_count), .cnt_full(s_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    x = b; x_valid = 1'b1; cfg_load = 1'b0;
    tick();
    x_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; x_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Sends bits MSB-first and checks y after each one against ymask.
  task automatic send_seq(input string tag, input int n, input logic [15:0] bits,
                          input logic [15:0] ymask);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i]);
      chk($sformatf("%s_y%0d", tag, n - i), y, ymask[i]);
    end
  endtask

  initial begin
    // 1: reset hold, then first detection
    rst = 1'b1;
    repeat (5) tick();
    chk("rst_y", y, 0);
    chk("rst_cnt", users_count, 0);
    chk("rst_full", cnt_full, 0);
    rst = 1'b0;
    send_seq("t1", 4, 16'b1011, 16'b0001);
    chk("t1_cnt", users_count, 1);
    tick();
    chk("t1_ydrop", y, 0);

    // 2: overlap vs non-overlap
    do_reset();
    overlap_en = 1'b1;
    send_seq("t2ov", 7, 16'b1011011, 16'b0001001);
    chk("t2ov_cnt", users_count, 2);
    do_reset();
    overlap_en = 1'b0;
    send_seq("t2no", 7, 16'b1011011, 16'b0001000);
    chk("t2no_cnt", users_count, 1);
    overlap_en = 1'b1;

    // 3: valid gap does not break the pattern
    do_reset();
    send_seq("t3a", 2, 16'b10, 16'b00);
    for (int i = 0; i < 6; i++) begin
      x = i[0]; x_valid = 1'b0;
      tick();
      chk($sformatf("t3_gap%0d", i), y, 0);
    end
    send_seq("t3b", 2, 16'b11, 16'b01);
    chk("t3_cnt", users_count, 1);

    // 4: cfg_load flushes history, discards its bit, keeps the count
    do_reset();
    send_seq("t4a", 7, 16'b1011101, 16'b0001000);
    chk("t4_cnt0", users_count, 1);
    cfg_pattern = 4'b0110; cfg_load = 1'b1; x = 1'b1; x_valid = 1'b1;
    tick();
    cfg_load = 1'b0; x_valid = 1'b0;
    chk("t4_load_y", y, 0);
    chk("t4_load_cnt", users_count, 1);
    send_seq("t4b", 4, 16'b0110, 16'b0001);
    chk("t4_cnt1", users_count, 2);

    // 5: counter limit on the 3-bit instance
    do_reset();
    cfg_pattern = 4'b1111; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    for (int i = 0; i < 10; i++) send(1'b1);
    chk("t5_cnt10", s_count, 7);
`ifdef SEQ_CNT_SATURATE_EN
    chk("t5_full10", s_full, 1);
`else
    chk("t5_full10", s_full, 0);
`endif
    send(1'b1);
    chk("t5_y11", s_y, 1);
`ifdef SEQ_CNT_SATURATE_EN
    chk("t5_cnt11", s_count, 7);
    chk("t5_full11", s_full, 1);
    tick();
    chk("t5_full_hold", s_full, 1);
`else
    chk("t5_cnt11", s_count, 0);
    chk("t5_full11", s_full, 1);
    tick();
    chk("t5_full_drop", s_full, 0);
`endif
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t5_clr_cnt", s_count, 0);
    chk("t5_clr_full", s_full, 0);

    // 6: clear coincident with a match, then reset mid-pattern
    do_reset();
    send_seq("t6a", 16, 16'b1011011011011011, 16'b0001001001001001);
    chk("t6_cnt5", users_count, 5);
    send(1'b0);
    send(1'b1);
    cnt_clr = 1'b1;
    send(1'b1);
    cnt_clr = 1'b0;
    chk("t6_clr_y", y, 1);
    chk("t6_clr_cnt", users_count, 1);
    send(1'b1); send(1'b0); send(1'b1);
    do_reset();
    chk("t6_rst_cnt", users_count, 0);
    send(1'b1);
    chk("t6_lone_y", y, 0);
    chk("t6_lone_cnt", users_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_pattern_counter.md
Name: seq_pattern_counter

Overview:
- Parametrised successor to the team's serial user detector.
- Watches a qualified serial bit stream for a programmable PAT_W-bit pattern, with overlapping or non-overlapping match mode selectable at run time.
- Pulses a detect flag and keeps a CNT_W-bit count of matches.
- Sits between the line sampler and the statistics/CSR block.

Parameters:
- PAT_W, 4: pattern length in bits (legal 2..16).
- PAT_INIT, 4'b1011: pattern loaded at reset. MSB is the oldest bit received.
- CNT_W, 10: width of the match counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- x  input  1  serial data bit.
- x_valid  input  1  x is sampled only when high.
- overlap_en  input  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- cfg_load  input  1  load cfg_pattern and flush history.
- cfg_pattern  input  PAT_W  new pattern; MSB is compared against the oldest bit.
- cnt_clr  input  1  clear match counter.
- y  output  1  registered one-cycle detect pulse.
- users_count  output  CNT_W  number of matches.
- cnt_full  output  1  counter limit indication (see Optional Feature).

Behaviour:
- Reset (rst high at a rising edge):
  - pattern reg <= PAT_INIT; shift reg <= 0; fill <= 0.
  - y, users_count and cnt_full <= 0.
  - rst overrides every other input.
- History:
  - shreg is PAT_W-1 bits.
  - On each valid bit: shreg <= {shreg[PAT_W-3:0], x}. Newest bit enters at the LSB.
  - fill counts valid bits held, 0..PAT_W-1, and saturates at PAT_W-1.
- Match condition (combinational): x_valid && fill == PAT_W-1 && {shreg, x} == pattern.
  - A match needs at least PAT_W valid bits since reset, load or the last non-overlap match.
- Latency:
  - y is high exactly one cycle, on the cycle after the edge that samples the completing bit.
  - users_count updates on the same edge as y.
- Cycles with x_valid low:
  - History, fill and counter hold.
  - y <= 0.
  - Gaps in x_valid do not break a pattern.
- Overlap mode:
  - overlap_en=1: fill stays at PAT_W-1 after a match, so a suffix of the match can start the next one.
  - overlap_en=0: on a match, fill <= 0 and shreg is treated as empty.
  - overlap_en is sampled every cycle. Changing it mid-stream affects only the next match decision.
- cfg_load (priority over x_valid):
  - pattern <= cfg_pattern; shreg <= 0; fill <= 0; y <= 0.
  - The bit presented in the load cycle is discarded.
  - users_count is unaffected.
- cnt_clr:
  - users_count <= 0.
  - If a match occurs in the same cycle, the clear applies first and then the increment, so users_count <= 1. y still pulses.
- Counter arithmetic:
  - Unsigned, CNT_W bits.
  - Behaviour at the maximum value 2^CNT_W-1 is set by the optional feature.
- No combinational path from inputs to outputs. All outputs are registered.

Optional Feature:
- Macro: SEQ_CNT_SATURATE_EN.
- Defined (saturating counter):
  - A match at 2^CNT_W-1 leaves users_count unchanged. y still pulses.
  - cnt_full is a level: high while users_count == 2^CNT_W-1.
  - cnt_clr drops cnt_full on the next cycle.
- Not defined (wrapping counter):
  - A match at 2^CNT_W-1 wraps users_count to 0.
  - cnt_full is a one-cycle pulse, coincident with y, on the wrap edge.
  - cnt_full is low otherwise.

Test Plan:
1. Reset hold 5 cycles, then release. Required: y=0, users_count=0, cnt_full=0; a following stream 1,0,1,1 (x_valid=1) gives y pulse one cycle after the 4th bit and users_count=1.
2. Default pattern 1011, overlap_en=1, stream 1,0,1,1,0,1,1. Required: y pulses after bits 4 and 7; users_count=2. Repeat with overlap_en=0 from reset. Required: one pulse after bit 4; users_count=1.
3. Stream 1,0 then x_valid low 6 cycles (x toggling), then 1,1. Required: a single y pulse after the final bit; nothing during the gap.
4. cfg_load with cfg_pattern=4'b0110 after bits 1,0,1 of a stream; that cycle's bit is discarded; then 0,1,1,0. Required: y pulse after the last 0; old partial history gives no match; users_count unchanged by the load.
5. CNT_W=3 instance, pattern 1111, overlap_en=1, 10 consecutive 1s. Required: users_count=7. 11th 1: with SEQ_CNT_SATURATE_EN, users_count stays 7 and cnt_full=1; without it, users_count=0 and cnt_full pulses for one cycle.
6. cnt_clr asserted in the same cycle as a completing bit, with users_count=5. Required: users_count=1 and y=1 on the next cycle. Then rst asserted mid-pattern (after 1,0,1) followed by a lone 1. Required: no y, users_count=0.
